// File: rtl/lcd_scan_ctrl_if.sv
// lcd_scan_ctrl_if: valid/ready draw port between the slot scanner and the LCD painter
interface lcd_scan_ctrl_if;
  logic        valid;
  logic        ready;
  logic [5:0]  slot;
  logic [39:0] name;
  logic [31:0] value;
  modport master (output valid, slot, name, value, input ready);
  modport slave (input valid, slot, name, value, output ready);
endinterface

// File: rtl/lcd_scan_ctrl.sv
// lcd_scan_ctrl: scans display slots onto a valid/ready draw port and assembles hex key entries
module lcd_scan_ctrl #(
  parameter int NUM_SLOTS = 44,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            scan_en,
  output logic [5:0]      display_number,
  input  logic            display_valid,
  input  logic [39:0]     display_name,
  input  logic [31:0]     display_value,
  lcd_scan_ctrl_if.master draw,
  output logic            frame_done,
  input  logic            key_valid,
  input  logic [4:0]      key_code,
  output logic [31:0]     entry_value,
  output logic            input_valid,
  output logic [31:0]     input_value
);
  localparam logic [5:0] LAST = 6'(NUM_SLOTS);
  localparam logic [3:0] SETTLE_END = 4'(SETTLE - 1);
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DRAW} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, digits;
  logic adv, load;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    adv = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: begin
        state_n = scan_en ? WAIT : IDLE;
        cnt_n = '0;
      end
      WAIT: begin
        state_n = cnt == SETTLE_END ? SAMPLE : WAIT;
        cnt_n = cnt == SETTLE_END ? cnt : cnt + 4'd1;
      end
      SAMPLE: begin
        load = display_valid;
        adv = !display_valid;
        state_n = display_valid ? DRAW : SAMPLE;
      end
      DRAW: adv = draw.ready;
      default: state_n = IDLE;
    endcase
    if (adv) begin
      state_n = scan_en ? WAIT : IDLE;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      display_number <= 6'd1;
      frame_done <= 1'b0;
      draw.valid <= 1'b0;
      draw.slot <= '0;
      draw.name <= '0;
      draw.value <= '0;
    end else begin
      frame_done <= adv && display_number == LAST;
      if (adv)
        display_number <= display_number == LAST ? 6'd1 : display_number + 6'd1;
      if (load) begin
        draw.valid <= 1'b1;
        draw.slot <= display_number;
        draw.name <= display_name;
        draw.value <= display_value;
      end else if (adv) begin
        draw.valid <= 1'b0;
      end
    end
  end
  // Digits past the eighth are dropped; enter doubles as clear after submitting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      entry_value <= '0;
      digits <= '0;
      input_valid <= 1'b0;
      input_value <= '0;
    end else begin
      input_valid <= key_valid && key_code == 5'd18;
      if (key_valid && key_code == 5'd18)
        input_value <= entry_value;
      if (key_valid && !key_code[4] && digits != 4'd8) begin
        entry_value <= {entry_value[27:0], key_code[3:0]};
        digits <= digits + 4'd1;
      end else if (key_valid && (key_code == 5'd16 || key_code == 5'd18)) begin
        entry_value <= '0;
        digits <= '0;
      end else if (key_valid && key_code == 5'd17) begin
        entry_value <= entry_value >> 4;
        digits <= digits == 4'd0 ? 4'd0 : digits - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// tb_lcd_scan_ctrl: directed bench with a registered wrapper model and a draw-transfer monitor
module tb_lcd_scan_ctrl;
  logic clk = 1'b0, resetn = 1'b0, scan_en = 1'b0, key_valid = 1'b0;
  logic [4:0] key_code = '0;
  logic [5:0] display_number;
  logic display_valid = 1'b0;
  logic [39:0] display_name = '0;
  logic [31:0] display_value = '0;
  logic frame_done, input_valid;
  logic [31:0] entry_value, input_value;
  logic [63:0] mask = '1;
  int checks = 0, failures = 0, cyc = 0, bad = 0;
  int xs[$], xc[$], fq[$];
  lcd_scan_ctrl_if dif();
  lcd_scan_ctrl dut (
    .clk(clk), .resetn(resetn), .scan_en(scan_en), .display_number(display_number),
    .display_valid(display_valid), .display_name(display_name), .display_value(display_value),
    .draw(dif), .frame_done(frame_done), .key_valid(key_valid), .key_code(key_code),
    .entry_value(entry_value), .input_valid(input_valid), .input_value(input_value)
  );
  always #5 clk = ~clk;
  // Wrapper model: registered lookup of the requested slot
  always @(posedge clk) begin
    cyc <= cyc + 1;
    display_valid <= mask[display_number];
    display_name <= {32'h534C4F54, 2'b00, display_number};
    display_value <= 32'hA000_0000 | {26'd0, display_number};
  end
  always @(negedge clk) begin
    if (resetn && dif.valid && dif.ready) begin
      xs.push_back(int'(dif.slot));
      xc.push_back(cyc);
      if (dif.name != {32'h534C4F54, 2'b00, dif.slot} || dif.value != (32'hA000_0000 | {26'd0, dif.slot}))
        bad++;
    end
    if (frame_done) fq.push_back(cyc);
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic key(input logic [4:0] c);
    key_valid = 1'b1;
    key_code = c;
    tick();
    key_valid = 1'b0;
  endtask
  task automatic wait_dn(input logic [5:0] n);
    int k = 0;
    while (display_number != n && k < 500) begin tick(); k++; end
    if (display_number != n) check("tmo_dn", display_number, n);
  endtask
  task automatic wait_valid;
    int k = 0;
    while (!dif.valid && k < 50) begin tick(); k++; end
    if (!dif.valid) check("tmo_valid", dif.valid, 1);
  endtask
  task automatic wait_x(input int n, input int budget);
    int k = 0;
    while (xs.size() < n && k < budget) begin tick(); k++; end
    if (xs.size() < n) check("tmo_xfer", xs.size(), n);
  endtask
  task automatic wait_fd(input int n, input int budget);
    int k = 0;
    while (fq.size() < n && k < budget) begin tick(); k++; end
    if (fq.size() < n) check("tmo_frame", fq.size(), n);
  endtask
  task automatic restart(input logic [63:0] m);
    resetn = 1'b0;
    scan_en = 1'b0;
    dif.ready = 1'b1;
    mask = m;
    tick();
    tick();
    xs.delete();
    xc.delete();
    fq.delete();
    bad = 0;
    resetn = 1'b1;
    scan_en = 1'b1;
  endtask
  task automatic check_reset(input string p);
    check({p, "_dn"}, display_number, 1);
    check({p, "_dvalid"}, dif.valid, 0);
    check({p, "_dslot"}, dif.slot, 0);
    check({p, "_dname"}, dif.name, 0);
    check({p, "_dvalue"}, dif.value, 0);
    check({p, "_fd"}, frame_done, 0);
    check({p, "_iv"}, input_valid, 0);
    check({p, "_ival"}, input_value, 0);
    check({p, "_entry"}, entry_value, 0);
  endtask
  initial begin
    int n0, n;
    logic [63:0] m;
    dif.ready = 1'b1;
    tick();
    tick();
    check_reset("rst");
    restart('1);
    wait_x(45, 400);
    for (int i = 0; i < xs.size() && i < 44; i++) check("t1_order", xs[i], i + 1);
    for (int i = 1; i < xs.size() && i < 45; i++) check("t1_gap", xc[i] - xc[i-1], 4);
    if (xs.size() > 44) check("t1_wrap", xs[44], 1);
    check("t1_payload", bad, 0);
    check("t1_fd_count", fq.size(), 1);
    if (fq.size() > 0 && xc.size() > 43) check("t1_fd_time", fq[0], xc[43] + 1);
    m = '0;
    m[38:7] = '1;
    restart(m);
    wait_fd(2, 600);
    n = 0;
    if (fq.size() > 1) begin
      for (int i = 0; i < xs.size(); i++)
        if (xc[i] > fq[0] && xc[i] < fq[1]) begin
          check("t2_slot", xs[i], 7 + n);
          n++;
        end
      check("t2_frame", fq[1] - fq[0], 164);
    end
    check("t2_draws", n, 32);
    restart('1);
    wait_dn(5);
    dif.ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("t3_valid", dif.valid, 1);
      check("t3_slot", dif.slot, 5);
      check("t3_value", dif.value, 32'hA000_0005);
      check("t3_dn", display_number, 5);
      tick();
    end
    n0 = xs.size();
    dif.ready = 1'b1;
    tick();
    check("t3_drop", dif.valid, 0);
    check("t3_dn_next", display_number, 6);
    wait_x(n0 + 2, 50);
    if (xs.size() > n0 + 1) begin
      check("t3_x5", xs[n0], 5);
      check("t3_x6", xs[n0 + 1], 6);
    end
    scan_en = 1'b0;
    key(5'd1);  check("k_1", entry_value, 32'h1);
    key(5'd2);  check("k_12", entry_value, 32'h12);
    key(5'd3);  check("k_123", entry_value, 32'h123);
    key(5'd10); check("k_123a", entry_value, 32'h123A);
    key(5'd17); check("k_bs", entry_value, 32'h123);
    key(5'd18);
    check("k_iv", input_valid, 1);
    check("k_ival", input_value, 32'h123);
    check("k_clr", entry_value, 0);
    tick();
    check("k_iv_off", input_valid, 0);
    check("k_ival_hold", input_value, 32'h123);
    for (int i = 0; i < 4; i++) key(5'd15);
    key(5'd25);
    check("k_ignore25", entry_value, 32'hFFFF);
    for (int i = 0; i < 5; i++) key(5'd15);
    check("k_f9", entry_value, 32'hFFFF_FFFF);
    key(5'd18);
    check("k_f_iv", input_valid, 1);
    check("k_f_ival", input_value, 32'hFFFF_FFFF);
    for (int d = 1; d <= 9; d++) key(5'(d));
    check("k_9th", entry_value, 32'h1234_5678);
    key(5'd17); check("k_bs8", entry_value, 32'h0123_4567);
    key(5'd9);  check("k_re8", entry_value, 32'h1234_5679);
    key(5'd16); check("k_clear", entry_value, 0);
    key(5'd17); check("k_bs0", entry_value, 0);
    key(5'd18);
    check("k_zero_iv", input_valid, 1);
    check("k_zero_ival", input_value, 0);
    restart('1);
    key(5'd7);
    key(5'd18);
    key(5'd3);
    check("t6_ival_pre", input_value, 7);
    wait_dn(20);
    dif.ready = 1'b0;
    wait_valid();
    check("t6_slot", dif.slot, 20);
    resetn = 1'b0;
    tick();
    check_reset("t6");
    resetn = 1'b1;
    dif.ready = 1'b1;
    n0 = xs.size();
    wait_x(n0 + 1, 50);
    if (xs.size() > n0) check("t6_restart", xs[n0], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_scan_ctrl.md
# lcd_scan_ctrl

Display-side controller for the touchscreen display/entry protocol used by the register-file and datapath display wrappers. It sweeps `display_number` over all slots, samples each slot's `display_valid`/`display_name`/`display_value` from the wrapper, and hands valid slots to the LCD painter over a valid/ready draw port. It also builds 32-bit values from hex key events and returns them to the wrapper as one-cycle `input_valid`/`input_value` pulses. It sits between the display wrapper and the LCD painter/touch decoder, replacing the protocol core of `lcd_module`.

## Interface
- `NUM_SLOTS`, 44: number of display slots, numbered 1..NUM_SLOTS.
- `SETTLE`, 2: cycles to wait after `display_number` changes before sampling (wrapper output is registered); legal values 1..15.

- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `scan_en` in 1: enables scanning; low parks the scanner after the current slot.
- `display_number` out 6: slot currently being requested.
- `display_valid` in 1: wrapper marks the slot as populated.
- `display_name` in 40: five ASCII characters.
- `display_value` in 32: slot value.
- `draw_valid` out 1: draw request.
- `draw_ready` in 1: painter accepts.
- `draw_slot` out 6, `draw_name` out 40, `draw_value` out 32: draw payload.
- `frame_done` out 1: one-cycle pulse when slot NUM_SLOTS completes.
- `key_valid` in 1: one key event this cycle.
- `key_code` in 5: 0..15 hex digit, 16 clear, 17 backspace, 18 enter, 19..31 ignored.
- `entry_value` out 32: value under construction, for echo.
- `input_valid` out 1: one-cycle submit pulse.
- `input_value` out 32: last submitted value.

## Operation
- Scan FSM states: IDLE, WAIT, SAMPLE, DRAW.
- IDLE: if `scan_en`=1, go to WAIT with counter=0. Otherwise stay.
- WAIT: count up. When the counter reaches SETTLE-1, go to SAMPLE.
- SAMPLE: if `display_valid`=1:
  - latch `draw_slot`=`display_number`, `draw_name`, `draw_value`;
  - set `draw_valid`=1;
  - go to DRAW.
- SAMPLE with `display_valid`=0: advance the slot.
- DRAW: hold `draw_valid` and the payload stable until `draw_ready`=1 (transfer cycle). Then clear `draw_valid` and advance the slot.
- Advance slot:
  - set `display_number` to `display_number`+1, wrapping from NUM_SLOTS to 1;
  - if the old slot was NUM_SLOTS, pulse `frame_done`;
  - next state is WAIT (counter=0) if `scan_en`=1, else IDLE.
- `scan_en` deasserting mid-slot never aborts WAIT, SAMPLE or DRAW.
- Entry logic runs independently of the scan FSM. It keeps `entry_value` and a digit count 0..8.
- Digit d:
  - if count<8: `entry_value`={`entry_value`[27:0], d} and count+1;
  - if count=8: ignored.
- Clear: `entry_value`=0, count=0.
- Backspace: `entry_value`=`entry_value`>>4, count=max(count-1,0).
- Enter:
  - `input_value`=`entry_value` and `input_valid`=1 for one cycle;
  - `entry_value`=0, count=0;
  - an enter with count=0 submits 0.
- Codes 19..31, or `key_valid`=0: no change.

## Timing
- Reset values:
  - `display_number`=1, state IDLE, counter=0;
  - `draw_valid`=0, `draw_slot`=0, `draw_name`=0, `draw_value`=0;
  - `frame_done`=0, `input_valid`=0, `input_value`=0, `entry_value`=0, count=0.
- Reset takes effect at any cycle, including mid-DRAW. A pending draw is dropped without handshake.
- `display_number` is constant for SETTLE+1 cycles before the SAMPLE edge.
- Per-slot cost with `draw_ready` held high:
  - valid slot: SETTLE+2 cycles;
  - invalid slot: SETTLE+1 cycles.
  - Default full frame, all slots valid: 44×4=176 cycles.
- `draw_valid` rises on the SAMPLE clock edge and falls on the edge after the transfer cycle. There are no back-to-back draws; at least SETTLE+1 cycles separate them.
- `frame_done` is asserted in the cycle after the slot-NUM_SLOTS advance edge.
- Key events take effect one edge later:
  - `entry_value` updates on the same edge as the key;
  - `input_valid` is high in the cycle after the enter edge;
  - `input_value` is stable from that cycle onward.

## Test plan
- Reset, then `scan_en`=1, all slots valid, `draw_ready`=1: draws occur for slots 1..44 in order, 4 cycles apart; one `frame_done`; the next draw is slot 1.
- Slots 7..38 valid, others invalid: only 32 draws (slots 7..38); frame length 12×3+32×4=164 cycles.
- `draw_ready` held low 10 cycles on slot 5: `draw_valid` and the payload are stable for all 10 cycles; `display_number` stays at 5; slot 6 follows after the transfer.
- Keys 1,2,3,A,backspace,enter: `entry_value` goes 0x1→0x12→0x123→0x123A→0x123; one `input_valid` pulse with `input_value`=0x123; `entry_value` returns to 0.
- Nine digits F, then enter: `input_value`=0xFFFFFFFF and the 9th digit is ignored. Code 25 mid-entry causes no change.
- `resetn` low during DRAW on slot 20: all outputs return to reset values; after release, scanning restarts from slot 1.
